// File: rtl/cart_mapper_wr_ctrl.sv
// CPU-side cartridge bus front end: decodes PRG-ROM/PRG-RAM cycles and sequences
// mapper register writes, optionally ANDing write data with the ROM byte (bus conflicts).
module cart_mapper_wr_ctrl #(
  parameter int unsigned BUS_CONFLICTS = 1,
  parameter int unsigned ROM_LATENCY   = 1,
  parameter int unsigned PRG_ROM_16K   = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cpu_addr_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  input  logic [7:0]  cpu_wr_data_i,
  input  logic [7:0]  prg_rom_data_i,
  output logic [14:0] prg_rom_addr_o,
  output logic        prg_rom_rd_o,
  output logic [12:0] prg_ram_addr_o,
  output logic        prg_ram_rd_o,
  output logic        prg_ram_wr_o,
  output logic        mapper_wr_o,
  output logic [7:0]  mapper_wr_data_o,
  output logic        busy_o,
  output logic        wr_drop_o
);

  typedef enum logic [1:0] {IDLE, CONF_RD, CONF_WAIT, COMMIT} state_t;

  localparam logic [14:0] ROM_MASK = (PRG_ROM_16K != 0) ? 15'h3FFF : 15'h7FFF;
  localparam logic [2:0]  CNT_INIT = 3'(ROM_LATENCY - 1);

  state_t      state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mapper_wr_q, mapper_wr_d;
  logic [7:0]  mapper_wr_data_q, mapper_wr_data_d;
  logic        wr_drop_q, wr_drop_d;

  logic rom_space, ram_space, rom_wr, rd_only, busy;

  assign rom_space = cpu_addr_i[15];
  assign ram_space = (cpu_addr_i[15:13] == 3'b011);
  assign rom_wr    = cpu_wr_i & rom_space;
  // a simultaneous write wins, so the read half of the cycle is discarded
  assign rd_only   = cpu_rd_i & ~cpu_wr_i;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    cnt_d            = cnt_q;
    mapper_wr_d      = 1'b0;
    mapper_wr_data_d = mapper_wr_data_q;
    wr_drop_d        = wr_drop_q;
    case (state_q)
      IDLE: begin
        if (rom_wr) begin
          addr_d  = cpu_addr_i[14:0];
          data_d  = cpu_wr_data_i;
          state_d = (BUS_CONFLICTS != 0) ? CONF_RD : COMMIT;
        end
      end
      CONF_RD: begin
        cnt_d   = CNT_INIT;
        state_d = CONF_WAIT;
      end
      CONF_WAIT: begin
        if (cnt_q == 3'd0) begin
          data_d  = prg_rom_data_i & data_q;
          state_d = COMMIT;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      COMMIT: begin
        mapper_wr_d      = 1'b1;
        mapper_wr_data_d = data_q;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (busy && rom_wr) wr_drop_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      data_q           <= '0;
      cnt_q            <= '0;
      mapper_wr_q      <= 1'b0;
      mapper_wr_data_q <= '0;
      wr_drop_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      data_q           <= data_d;
      cnt_q            <= cnt_d;
      mapper_wr_q      <= mapper_wr_d;
      mapper_wr_data_q <= mapper_wr_data_d;
      wr_drop_q        <= wr_drop_d;
    end
  end

  always_comb begin
    prg_rom_addr_o = (busy ? addr_q : cpu_addr_i[14:0]) & ROM_MASK;
    prg_rom_rd_o   = busy ? (state_q == CONF_RD) : (rd_only & rom_space);
    prg_ram_addr_o = cpu_addr_i[12:0];
    prg_ram_rd_o   = rd_only & ram_space;
    prg_ram_wr_o   = cpu_wr_i & ram_space;
  end

  assign mapper_wr_o      = mapper_wr_q;
  assign mapper_wr_data_o = mapper_wr_data_q;
  assign busy_o           = busy;
  assign wr_drop_o        = wr_drop_q;

endmodule

// File: tb/tb_cart_mapper_wr_ctrl.sv
// Directed bench: u_a conflicts/latency 2, u_b no conflicts, u_c conflicts/latency 1/16K mirror.
module tb_cart_mapper_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [7:0]  wdata = '0;

  logic [14:0] a_rom_addr, b_rom_addr, c_rom_addr;
  logic        a_rom_rd, b_rom_rd, c_rom_rd;
  logic [12:0] a_ram_addr, b_ram_addr, c_ram_addr;
  logic        a_ram_rd, b_ram_rd, c_ram_rd, a_ram_wr, b_ram_wr, c_ram_wr;
  logic        a_mw, b_mw, c_mw, a_busy, b_busy, c_busy, a_drop, b_drop, c_drop;
  logic [7:0]  a_md, b_md, c_md, a_rdata, c_rdata;
  logic [14:0] pa0, pa1, pc0;

  int total = 0, bad = 0;
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;
  int sa, sb, sc;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [14:0] a);
    return (a == 15'h0123) ? 8'hF1 : (a[7:0] ^ 8'h5A);
  endfunction

  // ROM models: data valid ROM_LATENCY cycles after the address is presented
  always @(posedge clk) begin
    pa0 <= a_rom_addr;
    pa1 <= pa0;
    pc0 <= c_rom_addr;
  end
  assign a_rdata = rom(pa1);
  assign c_rdata = rom(pc0);

  always @(negedge clk) begin
    if (a_mw) cnt_a++;
    if (b_mw) cnt_b++;
    if (c_mw) cnt_c++;
  end

  cart_mapper_wr_ctrl #(.BUS_CONFLICTS(1), .ROM_LATENCY(2), .PRG_ROM_16K(0)) u_a (
    .clk_i(clk), .rst_i(rst), .cpu_addr_i(addr), .cpu_rd_i(rd), .cpu_wr_i(wr),
    .cpu_wr_data_i(wdata), .prg_rom_data_i(a_rdata), .prg_rom_addr_o(a_rom_addr),
    .prg_rom_rd_o(a_rom_rd), .prg_ram_addr_o(a_ram_addr), .prg_ram_rd_o(a_ram_rd),
    .prg_ram_wr_o(a_ram_wr), .mapper_wr_o(a_mw), .mapper_wr_data_o(a_md),
    .busy_o(a_busy), .wr_drop_o(a_drop));

  cart_mapper_wr_ctrl #(.BUS_CONFLICTS(0), .ROM_LATENCY(1), .PRG_ROM_16K(0)) u_b (
    .clk_i(clk), .rst_i(rst), .cpu_addr_i(addr), .cpu_rd_i(rd), .cpu_wr_i(wr),
    .cpu_wr_data_i(wdata), .prg_rom_data_i(8'h00), .prg_rom_addr_o(b_rom_addr),
    .prg_rom_rd_o(b_rom_rd), .prg_ram_addr_o(b_ram_addr), .prg_ram_rd_o(b_ram_rd),
    .prg_ram_wr_o(b_ram_wr), .mapper_wr_o(b_mw), .mapper_wr_data_o(b_md),
    .busy_o(b_busy), .wr_drop_o(b_drop));

  cart_mapper_wr_ctrl #(.BUS_CONFLICTS(1), .ROM_LATENCY(1), .PRG_ROM_16K(1)) u_c (
    .clk_i(clk), .rst_i(rst), .cpu_addr_i(addr), .cpu_rd_i(rd), .cpu_wr_i(wr),
    .cpu_wr_data_i(wdata), .prg_rom_data_i(c_rdata), .prg_rom_addr_o(c_rom_addr),
    .prg_rom_rd_o(c_rom_rd), .prg_ram_addr_o(c_ram_addr), .prg_ram_rd_o(c_ram_rd),
    .prg_ram_wr_o(c_ram_wr), .mapper_wr_o(c_mw), .mapper_wr_data_o(c_md),
    .busy_o(c_busy), .wr_drop_o(c_drop));

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] a, input logic r, input logic w, input logic [7:0] d);
    addr = a; rd = r; wr = w; wdata = d;
  endtask

  task automatic snap();
    sa = cnt_a; sb = cnt_b; sc = cnt_c;
  endtask

  typedef struct {
    logic [15:0] a; logic r; logic w;
    logic [14:0] rom_addr; logic [14:0] rom_addr16k; logic rom_rd;
    logic [12:0] ram_addr; logic ram_rd; logic ram_wr;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h8000, 1, 0, 15'h0000, 15'h0000, 1, 13'h0000, 0, 0};
    vecs[1] = '{16'hC010, 1, 0, 15'h4010, 15'h0010, 1, 13'h0010, 0, 0};
    vecs[2] = '{16'hFFFF, 1, 0, 15'h7FFF, 15'h3FFF, 1, 13'h1FFF, 0, 0};
    vecs[3] = '{16'h6005, 1, 0, 15'h6005, 15'h2005, 0, 13'h0005, 1, 0};
    vecs[4] = '{16'h7FFF, 0, 1, 15'h7FFF, 15'h3FFF, 0, 13'h1FFF, 0, 1};
    vecs[5] = '{16'h6005, 1, 1, 15'h6005, 15'h2005, 0, 13'h0005, 0, 1};
    vecs[6] = '{16'h4000, 1, 0, 15'h4000, 15'h0000, 0, 13'h0000, 0, 0};
    vecs[7] = '{16'h4000, 0, 1, 15'h4000, 15'h0000, 0, 13'h0000, 0, 0};
    vecs[8] = '{16'h5FFF, 1, 0, 15'h5FFF, 15'h1FFF, 0, 13'h1FFF, 0, 0};
    vecs[9] = '{16'h0000, 0, 0, 15'h0000, 15'h0000, 0, 13'h0000, 0, 0};

    // reset state
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("rst_mw", 16'(a_mw), 16'h0);
    chk("rst_md", 16'(a_md), 16'h00);
    chk("rst_busy", 16'(a_busy), 16'h0);
    chk("rst_drop", 16'(a_drop), 16'h0);

    // IDLE passthrough table
    for (int i = 0; i < 10; i++) begin
      step();
      drive(vecs[i].a, vecs[i].r, vecs[i].w, 8'h55);
      #1;
      chk($sformatf("v%0d_rom_addr", i), 16'(a_rom_addr), 16'(vecs[i].rom_addr));
      chk($sformatf("v%0d_rom_addr16k", i), 16'(c_rom_addr), 16'(vecs[i].rom_addr16k));
      chk($sformatf("v%0d_rom_rd", i), 16'(a_rom_rd), 16'(vecs[i].rom_rd));
      chk($sformatf("v%0d_ram_addr", i), 16'(a_ram_addr), 16'(vecs[i].ram_addr));
      chk($sformatf("v%0d_ram_rd", i), 16'(a_ram_rd), 16'(vecs[i].ram_rd));
      chk($sformatf("v%0d_ram_wr", i), 16'(a_ram_wr), 16'(vecs[i].ram_wr));
    end
    step();
    drive(16'h0000, 0, 0, 8'h00);
    chk("tbl_busy_b", 16'(b_busy), 16'h0);
    chk("tbl_busy_a", 16'(a_busy), 16'h0);
    repeat (3) step();
    chk("tbl_no_strobe", 16'(cnt_a + cnt_b + cnt_c), 16'h0);

    // conflict write 0x03 -> $8123, RAM write and ROM read while busy
    snap();
    drive(16'h8123, 0, 1, 8'h03);
    step();
    drive(16'h0000, 0, 0, 8'h00);
    #1;
    chk("A_a_rom_rd", 16'(a_rom_rd), 16'h1);
    chk("A_a_rom_addr", 16'(a_rom_addr), 16'h0123);
    chk("A_a_busy1", 16'(a_busy), 16'h1);
    chk("A_b_busy", 16'(b_busy), 16'h1);
    chk("A_b_rom_rd", 16'(b_rom_rd), 16'h0);
    chk("A_c_rom_rd", 16'(c_rom_rd), 16'h1);
    step();
    chk("A_b_mw", 16'(b_mw), 16'h1);
    chk("A_b_md", 16'(b_md), 16'h03);
    chk("A_a_rom_rd2", 16'(a_rom_rd), 16'h0);
    chk("A_a_busy2", 16'(a_busy), 16'h1);
    drive(16'h6005, 0, 1, 8'hAA);
    #1;
    chk("A_ram_wr", 16'(a_ram_wr), 16'h1);
    chk("A_ram_addr", 16'(a_ram_addr), 16'h0005);
    chk("A_rom_addr_hold", 16'(a_rom_addr), 16'h0123);
    step();
    drive(16'h9000, 1, 0, 8'h00);
    #1;
    chk("A_a_rd_blocked", 16'(a_rom_rd), 16'h0);
    chk("A_a_addr_hold2", 16'(a_rom_addr), 16'h0123);
    chk("A_b_rd_pass", 16'(b_rom_rd), 16'h1);
    chk("A_b_rd_addr", 16'(b_rom_addr), 16'h1000);
    chk("A_b_mw_off", 16'(b_mw), 16'h0);
    chk("A_a_busy3", 16'(a_busy), 16'h1);
    step();
    drive(16'h0000, 0, 0, 8'h00);
    chk("A_c_mw", 16'(c_mw), 16'h1);
    chk("A_c_md", 16'(c_md), 16'h01);
    chk("A_a_mw_early", 16'(a_mw), 16'h0);
    chk("A_a_busy4", 16'(a_busy), 16'h1);
    step();
    chk("A_a_mw", 16'(a_mw), 16'h1);
    chk("A_a_md", 16'(a_md), 16'h01);
    chk("A_a_busy_done", 16'(a_busy), 16'h0);
    step();
    chk("A_a_mw_off", 16'(a_mw), 16'h0);
    chk("A_a_md_hold", 16'(a_md), 16'h01);
    chk("A_cnt_a", 16'(cnt_a - sa), 16'h1);
    chk("A_cnt_b", 16'(cnt_b - sb), 16'h1);
    chk("A_cnt_c", 16'(cnt_c - sc), 16'h1);

    // 16K mirror: conflict write to $E000 reads ROM at 0x2000
    snap();
    drive(16'hE000, 0, 1, 8'hFF);
    step();
    drive(16'h0000, 0, 0, 8'h00);
    #1;
    chk("K_c_rom_rd", 16'(c_rom_rd), 16'h1);
    chk("K_c_rom_addr", 16'(c_rom_addr), 16'h2000);
    chk("K_a_rom_addr", 16'(a_rom_addr), 16'h6000);
    repeat (3) step();
    chk("K_c_mw", 16'(c_mw), 16'h1);
    chk("K_c_md", 16'(c_md), 16'h5A);
    repeat (2) step();
    chk("K_a_md", 16'(a_md), 16'h5A);
    chk("K_b_md", 16'(b_md), 16'hFF);
    chk("K_cnt_a", 16'(cnt_a - sa), 16'h1);
    chk("K_cnt_c", 16'(cnt_c - sc), 16'h1);

    // second ROM write while busy is dropped
    step();
    snap();
    chk("D_drop_pre", 16'(a_drop), 16'h0);
    drive(16'h8000, 0, 1, 8'h07);
    step();
    drive(16'h8001, 0, 1, 8'hFF);
    step();
    drive(16'h0000, 0, 0, 8'h00);
    #1;
    chk("D_a_drop", 16'(a_drop), 16'h1);
    chk("D_b_drop", 16'(b_drop), 16'h1);
    repeat (6) step();
    chk("D_cnt_a", 16'(cnt_a - sa), 16'h1);
    chk("D_a_md", 16'(a_md), 16'h02);
    chk("D_cnt_b", 16'(cnt_b - sb), 16'h1);
    chk("D_b_md", 16'(b_md), 16'h07);
    chk("D_a_drop_sticky", 16'(a_drop), 16'h1);

    // reset in CONF_WAIT aborts the sequence
    snap();
    drive(16'h8000, 0, 1, 8'h03);
    step();
    drive(16'h0000, 0, 0, 8'h00);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("R_a_busy", 16'(a_busy), 16'h0);
    chk("R_c_busy", 16'(c_busy), 16'h0);
    chk("R_a_md", 16'(a_md), 16'h00);
    chk("R_b_md", 16'(b_md), 16'h00);
    chk("R_a_drop", 16'(a_drop), 16'h0);
    repeat (5) step();
    chk("R_cnt_a", 16'(cnt_a - sa), 16'h0);
    chk("R_cnt_c", 16'(cnt_c - sc), 16'h0);
    chk("R_cnt_b", 16'(cnt_b - sb), 16'h1);

    // unmapped write at $4000
    snap();
    drive(16'h4000, 0, 1, 8'h03);
    #1;
    chk("U_ram_wr", 16'(a_ram_wr), 16'h0);
    chk("U_rom_rd", 16'(a_rom_rd), 16'h0);
    step();
    drive(16'h0000, 0, 0, 8'h00);
    chk("U_a_busy", 16'(a_busy), 16'h0);
    chk("U_b_busy", 16'(b_busy), 16'h0);
    repeat (3) step();
    chk("U_cnt", 16'((cnt_a - sa) + (cnt_b - sb) + (cnt_c - sc)), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
